// File: rtl/operand_sel_seq.sv
// operand_sel_seq: registered, handshaked operand selector feeding the
// Montgomery multiplier. A request captures one of {a, b, one, zero} and
// delivers it either as a single parallel word (valid/ready) or as an
// LSB-first bit stream for the bit-serial multiplier core.
// All outputs are decoded from registered state, so there is no
// combinational path from a, b or sel to any output.
module operand_sel_seq #(
    parameter int WIDTH = 10,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_WORD = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] src_word;
    logic             accept;
    logic             at_last;

    // Fully decoded source select; every sel code is legal.
    always_comb begin
        src_word = '0;
        case (sel)
            2'b00:   src_word = a;
            2'b01:   src_word = b;
            2'b10:   src_word = ONE_WORD;
            default: src_word = '0;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign at_last = (cnt_reg == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and output decode. HOLD passes out_ready through to
    // in_ready so a new request can be taken on the same edge the current
    // word leaves, giving one word per cycle with no idle gap.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        bit_valid  = 1'b0;
        bit_last   = 1'b0;
        bit_out    = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_next = mode ? SHIFT : HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_next = mode ? SHIFT : HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = shift_reg[0];
                bit_last  = at_last;
                if (bit_ready && at_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, shift one bit per transferred beat.
    // Stalled beats (bit_ready low) leave shift register and counter alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg  <= '0;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (accept) begin
            word_reg  <= src_word;
            shift_reg <= src_word;
            cnt_reg   <= '0;
        end else if (state_reg == SHIFT && bit_ready) begin
            shift_reg <= shift_reg >> 1;
            cnt_reg   <= at_last ? '0 : cnt_reg + 1'b1;
        end
    end

    assign out_data = word_reg;

endmodule
